// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian bytes into 32-bit words and writes them to instruction memory
module imem_loader #(
  parameter int N = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_byte_data,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_rst_n
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
  state_t      state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word;
  logic [15:0] len;
  logic        take;
  assign take         = i_byte_valid && o_byte_ready;
  assign len          = {i_byte_data, count[7:0]};
  assign o_byte_ready = state == LEN0 || state == LEN1 || state == DATA;
  assign o_wr_en      = state == WRITE;
  assign o_busy       = o_byte_ready || o_wr_en;
  assign o_done       = state == DONE;
  assign o_err        = state == ERR;
  assign o_cpu_rst_n  = state == DONE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      count     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      word      <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: if (i_start) begin
          state    <= LEN0;
          word_idx <= '0;
          byte_idx <= '0;
        end
        LEN0: if (take) begin
          count[7:0] <= i_byte_data;
          state      <= LEN1;
        end
        LEN1: if (take) begin
          count[15:8] <= i_byte_data;
          byte_idx    <= '0;
          word_idx    <= '0;
          state       <= len == 16'd0 ? DONE : {16'b0, len} > N ? ERR : DATA;
        end
        DATA: if (take) begin
          byte_idx <= byte_idx + 2'd1;
          word     <= {i_byte_data, word[23:8]};
          if (byte_idx == 2'd3) begin
            o_wr_addr <= {14'b0, word_idx, 2'b00};
            o_wr_data <= {i_byte_data, word};
            state     <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          byte_idx <= '0;
          state    <= word_idx + 16'd1 == count ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int N = 2048;
  typedef logic [7:0] bq_t[$];
  logic        i_clk = 0;
  logic        i_rst_n = 0;
  logic        i_start = 0;
  logic [7:0]  i_byte_data = 0;
  logic        i_byte_valid = 0;
  logic        o_byte_ready, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n;
  logic [31:0] o_wr_addr, o_wr_data;
  logic [63:0] exp_q[$];
  int passed = 0;
  int total = 0;
  always #5 i_clk = ~i_clk;
  imem_loader #(.N(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_byte_data(i_byte_data), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cpu_rst_n(o_cpu_rst_n)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(o_wr_en), 0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", o_wr_addr, e[63:32]);
        chk("wr_data", o_wr_data, e[31:0]);
      end
    end
  end
  function automatic int model(input bq_t b);
    int len;
    len = {b[1], b[0]};
    if (len > N) return 1;
    for (int w = 0; w < len; w++)
      exp_q.push_back({32'(w * 4), b[4*w+5], b[4*w+4], b[4*w+3], b[4*w+2]});
    return 0;
  endfunction
  task automatic start();
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
  endtask
  task automatic send(input bq_t b, input int stall, input int mid_start);
    int n;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, stall)) @(negedge i_clk);
      i_byte_valid = 1;
      i_byte_data = b[i];
      i_start = (mid_start != 0 && i == 4);
      n = 0;
      while (!o_byte_ready && n < 100) begin
        @(negedge i_clk);
        n++;
      end
      if (!o_byte_ready) begin
        chk("ready_timeout", 32'(o_byte_ready), 1);
        i_byte_valid = 0;
        i_start = 0;
        return;
      end
      @(posedge i_clk);
      #1 i_byte_valid = 0;
      i_start = 0;
      @(negedge i_clk);
      if (i >= 5 && i % 4 == 1) chk("wr_latency", 32'(o_wr_en), 1);
    end
  endtask
  task automatic session(input bq_t b, input int stall, input int mid_start);
    int err;
    int n;
    err = model(b);
    start();
    chk("busy_after_start", 32'(o_busy), 1);
    send(b, stall, mid_start);
    n = 0;
    while (o_busy && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("busy_end", 32'(o_busy), 0);
    chk("done", 32'(o_done), 32'(err == 0));
    chk("err", 32'(o_err), 32'(err != 0));
    chk("cpu_rst_n", 32'(o_cpu_rst_n), 32'(err == 0));
    chk("ready_end", 32'(o_byte_ready), 0);
    chk("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_byte_ready), 0);
    chk({tag, "_wr_en"}, 32'(o_wr_en), 0);
    chk({tag, "_wr_addr"}, o_wr_addr, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    chk({tag, "_cpu_rst_n"}, 32'(o_cpu_rst_n), 0);
  endtask
  initial begin
    bq_t normal, b;
    int len;
    normal = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    #1 check_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;
    session(normal, 0, 0);
    b = '{8'h00, 8'h00};
    session(b, 0, 0);
    b = '{8'h01, 8'h08};
    session(b, 0, 0);
    session(normal, 5, 0);
    session(normal, 2, 1);
    start();
    b = '{8'h02, 8'h00, 8'h13, 8'h00};
    send(b, 2, 0);
    i_rst_n = 0;
    #1 check_zero("mid_reset");
    @(negedge i_clk);
    i_rst_n = 1;
    session(normal, 3, 0);
    repeat (8) begin
      len = $urandom_range(1, 6);
      b = {};
      b.push_back(8'(len));
      b.push_back(8'(len >> 8));
      repeat (4 * len) b.push_back(8'($urandom));
      session(b, 5, $urandom_range(0, 1));
    end
    len = $urandom_range(N + 1, 65535);
    b = {};
    b.push_back(8'(len));
    b.push_back(8'(len >> 8));
    session(b, 3, 0);
    b = {};
    b.push_back(8'(N + 1));
    b.push_back(8'((N + 1) >> 8));
    session(b, 0, 0);
    b = {};
    b.push_back(8'(N));
    b.push_back(8'(N >> 8));
    repeat (4 * N) b.push_back(8'($urandom));
    session(b, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: N, default 2048, depth in 32-bit words of the instruction memory being written.
REQ-002 Port: i_clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: i_start  input  1  single-cycle request to begin a load session.
REQ-005 Port: i_byte_data  input  8  incoming program byte, for example from a UART receiver.
REQ-006 Port: i_byte_valid  input  1  i_byte_data is valid this cycle.
REQ-007 Port: o_byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port: o_wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: o_wr_addr  output  32  byte address of the write, word-aligned with bits [1:0] = 0.
REQ-010 Port: o_wr_data  output  32  assembled instruction word.
REQ-011 Port: o_busy  output  1  load session in progress.
REQ-012 Port: o_done  output  1  last load completed successfully.
REQ-013 Port: o_err  output  1  last load aborted because the length was illegal.
REQ-014 Port: o_cpu_rst_n  output  1  active-low core reset; high only after a successful load.

Function
REQ-015 The loader SHALL transfer a byte only on a rising edge where i_byte_valid=1 and o_byte_ready=1.
REQ-016 The loader SHALL use states IDLE, LEN0, LEN1, DATA, WRITE, DONE and ERR.
REQ-017 o_byte_ready SHALL be 1 in LEN0, LEN1 and DATA, and 0 in all other states.
REQ-018 In IDLE, DONE and ERR, the loader SHALL move to LEN0 on i_start=1, clear o_done, o_err and the word index, and ignore all bytes.
REQ-019 i_start SHALL be ignored in LEN0, LEN1, DATA and WRITE.
REQ-020 In LEN0, an accepted byte SHALL become count[7:0], and the state SHALL move to LEN1.
REQ-021 In LEN1, an accepted byte SHALL become count[15:8], with the next state chosen as follows:
- count==0: DONE.
- count>N: ERR.
- otherwise: DATA, with byte index 0 and word index 0.
REQ-022 In DATA, accepted byte k (k=0..3) SHALL be placed at word bits [8k+7:8k] (little-endian), and the 4th byte SHALL move the state to WRITE.
REQ-023 WRITE SHALL last exactly one cycle with the following outputs:
- o_wr_en=1.
- o_wr_addr = word_index*4.
- o_wr_data = the assembled word.
REQ-024 WRITE latency: o_wr_en SHALL be high in the cycle immediately after the edge that accepted the 4th byte.
REQ-025 After WRITE, the word index SHALL increment; the state SHALL go to DONE if the incremented index equals count, else back to DATA with byte index 0.
REQ-026 o_wr_en SHALL be 0 in every state other than WRITE; o_wr_addr and o_wr_data SHALL hold their last values outside WRITE.
REQ-027 o_busy SHALL be 1 in LEN0, LEN1, DATA and WRITE.
REQ-028 o_done SHALL be 1 only in DONE, and o_err SHALL be 1 only in ERR; each SHALL hold until the next i_start or reset.
REQ-029 o_cpu_rst_n SHALL be 1 only in DONE.
REQ-030 An indefinite deassertion of i_byte_valid SHALL stall the loader without loss or duplication of bytes or writes.
REQ-031 Word index and count SHALL be 16 bits wide; o_wr_addr SHALL be the word index zero-extended and shifted left by 2.

Reset
REQ-032 Asserting i_rst_n=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE.
REQ-033 During reset, the following outputs SHALL be 0:
- o_byte_ready, o_wr_en, o_wr_addr, o_wr_data.
- o_busy, o_done, o_err, o_cpu_rst_n.
REQ-034 During reset, all internal counters and the word register SHALL be 0.
REQ-035 Reset asserted mid-session SHALL abandon the partial word with no further write, and a later i_start SHALL reload from address 0.

Verification
REQ-036 Normal load: i_start, then bytes 02 00 13 00 00 00 93 00 10 00 -> writes (addr 0x0, data 0x00000013) then (addr 0x4, data 0x00100093) -> o_done=1, o_cpu_rst_n=1.
REQ-037 Zero length: i_start, then bytes 00 00 -> DONE with no o_wr_en pulse.
REQ-038 Oversize length (N=2048): i_start, then bytes 01 08 -> o_err=1, o_byte_ready=0, no writes, o_cpu_rst_n=0.
REQ-039 Stalled stream: the normal load with i_byte_valid low 0-5 random cycles between bytes -> identical writes, exactly one o_wr_en per word.
REQ-040 Reset mid-word: reset after 2 data bytes -> all outputs 0; then the normal load -> first write at addr 0x0.
REQ-041 Ignored start: i_start pulsed during DATA -> no state change, and the load completes as in REQ-036.
